// File: rtl/codec_config_sequencer.sv
// codec_config_sequencer
//   Writes the fixed WM8731 register table over I2C after reset (or on a
//   start pulse once idle) and flags the codec as ready.
//   Each word is sent as START, 0x34, {addr, data[8]}, data[7:0], STOP, GAP.
//   A NACK aborts the frame and retries the word up to MAX_RETRY times.
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   start          pulse to re-run the table (honoured only when not busy)
//   sdat_in        sampled SDAT pin level
//   sclk           SCL, push-pull
//   sdat_oe        1 pulls SDAT low, 0 releases it to the pull-up
//   busy           table run in progress
//   done           all words ACKed (held until the next run)
//   error          a word ran out of retries (held until the next run)
//   word_idx       index of the word being written (0..10)
module codec_config_sequencer #(
  parameter int unsigned CLK_DIV   = 125,
  parameter int unsigned MAX_RETRY = 3,
  parameter logic [6:0]  DEV_ADDR  = 7'h1A
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       sdat_in,
  output logic       sclk,
  output logic       sdat_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] word_idx
);

  localparam int unsigned   QW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned   RW        = $clog2(MAX_RETRY + 2);
  localparam logic [QW-1:0] Q_LAST    = QW'(CLK_DIV - 1);
  localparam logic [RW-1:0] R_MAX     = RW'(MAX_RETRY);
  localparam logic [3:0]    LAST_WORD = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t        state, state_n;
  logic [QW-1:0] q_cnt, q_cnt_n;
  logic [1:0]    phase, phase_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [1:0]    byte_cnt, byte_cnt_n;
  logic [RW-1:0] retry, retry_n;
  logic          nack, nack_n;
  logic [3:0]    word_n;
  logic          sclk_n, sdat_oe_n, busy_n, done_n, error_n;
  logic          tick;
  logic [15:0]   word_data;
  logic [7:0]    cur_byte;
  logic          sdat_bit;

  // {register address, 9-bit data}
  function automatic logic [15:0] table_word(input logic [3:0] idx);
    case (idx)
      4'd0:    table_word = {7'd15, 9'h000};
      4'd1:    table_word = {7'd6,  9'h000};
      4'd2:    table_word = {7'd0,  9'h017};
      4'd3:    table_word = {7'd1,  9'h017};
      4'd4:    table_word = {7'd2,  9'h079};
      4'd5:    table_word = {7'd3,  9'h079};
      4'd6:    table_word = {7'd4,  9'h012};
      4'd7:    table_word = {7'd5,  9'h000};
      4'd8:    table_word = {7'd7,  9'h042};
      4'd9:    table_word = {7'd8,  9'h000};
      default: table_word = {7'd9,  9'h001};
    endcase
  endfunction

  assign tick = (q_cnt == Q_LAST);

  // Outputs are decoded from the next-state values and then registered, so
  // the pins change on the same edge the FSM enters a phase.
  always_comb begin
    state_n    = state;
    q_cnt_n    = tick ? '0 : q_cnt + 1'b1;
    phase_n    = phase;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    retry_n    = retry;
    nack_n     = nack;
    word_n     = word_idx;
    sclk_n     = 1'b1;
    sdat_oe_n  = 1'b0;
    busy_n     = 1'b1;
    done_n     = 1'b0;
    error_n    = 1'b0;

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        q_cnt_n = '0;
        if (state == S_IDLE || start) begin
          state_n = S_START;
          phase_n = '0;
          word_n  = '0;
          retry_n = '0;
          nack_n  = 1'b0;
        end
      end
      S_START: if (tick) begin
        if (phase == 2'd1) begin
          state_n    = S_BIT;
          phase_n    = '0;
          bit_cnt_n  = '0;
          byte_cnt_n = '0;
        end else begin
          phase_n = phase + 2'd1;
        end
      end
      S_BIT: if (tick) begin
        phase_n = phase + 2'd1;
        if (phase == 2'd3) begin
          phase_n = '0;
          if (bit_cnt == 3'd7) state_n = S_ACK;
          else                 bit_cnt_n = bit_cnt + 3'd1;
        end
      end
      S_ACK: if (tick) begin
        phase_n = phase + 2'd1;
        if (phase == 2'd2) nack_n = sdat_in;
        if (phase == 2'd3) begin
          phase_n = '0;
          if (nack || byte_cnt == 2'd2) begin
            state_n = S_STOP;
          end else begin
            state_n    = S_BIT;
            bit_cnt_n  = '0;
            byte_cnt_n = byte_cnt + 2'd1;
          end
        end
      end
      S_STOP: if (tick) begin
        phase_n = phase + 2'd1;
        if (phase == 2'd2) begin
          state_n = S_GAP;
          phase_n = '0;
        end
      end
      S_GAP: if (tick) begin
        phase_n = phase + 2'd1;
        if (phase == 2'd3) begin
          // Even the final failing attempt is closed with STOP and GAP
          // before ERR, so the bus is always left idle.
          phase_n = '0;
          nack_n  = 1'b0;
          if (nack) begin
            if (retry == R_MAX) begin
              state_n = S_ERR;
            end else begin
              retry_n = retry + 1'b1;
              state_n = S_START;
            end
          end else if (word_idx == LAST_WORD) begin
            state_n = S_DONE;
          end else begin
            word_n  = word_idx + 4'd1;
            retry_n = '0;
            state_n = S_START;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    word_data = table_word(word_n);
    case (byte_cnt_n)
      2'd0:    cur_byte = {DEV_ADDR, 1'b0};
      2'd1:    cur_byte = word_data[15:8];
      default: cur_byte = word_data[7:0];
    endcase
    sdat_bit = cur_byte[3'd7 - bit_cnt_n];

    case (state_n)
      S_IDLE: busy_n = 1'b0;
      S_START: begin
        sclk_n    = (phase_n == 2'd0);
        sdat_oe_n = 1'b1;
      end
      S_BIT: begin
        sclk_n    = phase_n[1];
        sdat_oe_n = ~sdat_bit;
      end
      S_ACK: sclk_n = phase_n[1];
      S_STOP: begin
        sclk_n    = (phase_n != 2'd0);
        sdat_oe_n = (phase_n != 2'd2);
      end
      S_DONE: begin
        busy_n = 1'b0;
        done_n = 1'b1;
      end
      S_ERR: begin
        busy_n  = 1'b0;
        error_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      q_cnt    <= '0;
      phase    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      retry    <= '0;
      nack     <= 1'b0;
      word_idx <= '0;
      sclk     <= 1'b1;
      sdat_oe  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_n;
      q_cnt    <= q_cnt_n;
      phase    <= phase_n;
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      retry    <= retry_n;
      nack     <= nack_n;
      word_idx <= word_n;
      sclk     <= sclk_n;
      sdat_oe  <= sdat_oe_n;
      busy     <= busy_n;
      done     <= done_n;
      error    <= error_n;
    end
  end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Self-checking bench for codec_config_sequencer: an I2C slave/bus monitor
// decodes every frame and checks bus timing, and a word-level model predicts
// frames, run length and final flags for each run.
module tb_codec_config_sequencer;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned MAX_RETRY = 3;
  localparam logic [6:0] T_ADDR [11] = '{7'd15, 7'd6, 7'd0, 7'd1, 7'd2, 7'd3,
                                          7'd4, 7'd5, 7'd7, 7'd8, 7'd9};
  localparam logic [8:0] T_DATA [11] = '{9'h000, 9'h000, 9'h017, 9'h017, 9'h079,
                                          9'h079, 9'h012, 9'h000, 9'h042, 9'h000, 9'h001};

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       start   = 1'b0;
  logic       sdat_in = 1'b1;
  logic       sclk, sdat_oe, busy, done, error;
  logic [3:0] word_idx;

  codec_config_sequencer #(
    .CLK_DIV  (CLK_DIV),
    .MAX_RETRY(MAX_RETRY),
    .DEV_ADDR (7'h1A)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .sdat_in (sdat_in),
    .sclk    (sclk),
    .sdat_oe (sdat_oe),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .word_idx(word_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // slave NACK policy: frames [nack_frame, nack_frame+nack_cnt) NACK byte nack_byte
  int nack_frame = 0, nack_byte = 0, nack_cnt = 0;

  // bus monitor / slave state
  int unsigned cyc = 0;
  int unsigned rise_cyc = 0, stop_cyc = 0, busy_rise_cyc = 0;
  int          busy_rises = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1, prev_busy = 1'b0;
  logic slave_pull = 1'b0, ack_pending = 1'b0, ack_pull = 1'b0;
  logic in_frame = 1'b0, high_clean = 1'b0, stop_valid = 1'b0;
  int   nbits = 0, nbytes = 0, frame_no = 0, cur_frame = 0;
  logic [7:0]  shreg = '0;
  logic [23:0] acc = '0;
  logic [31:0] dec_q[$];
  logic [31:0] exp_q[$];

  always @(posedge clk) begin
    logic line;
    logic nk;
    cyc = cyc + 1;
    #1;
    if (!reset_n) begin
      prev_scl = 1'b1; prev_sda = 1'b1; prev_busy = 1'b0;
      slave_pull = 1'b0; ack_pending = 1'b0; in_frame = 1'b0;
      high_clean = 1'b0; stop_valid = 1'b0; sdat_in = 1'b1;
    end else begin
      if (busy && !prev_busy) begin
        busy_rise_cyc = cyc;
        busy_rises++;
        frame_no = 0;
        dec_q.delete();
      end
      if (prev_scl && !sclk) begin
        if (high_clean) check("scl_high_time", int'(cyc - rise_cyc), 2 * CLK_DIV);
        high_clean = 1'b0;
        if (slave_pull) slave_pull = 1'b0;
        else if (ack_pending) begin
          slave_pull  = ack_pull;
          ack_pending = 1'b0;
        end
      end
      line = !(sdat_oe || slave_pull);
      sdat_in = line;
      if (prev_scl && sclk && (prev_sda != line)) begin
        high_clean = 1'b0;
        if (!line) begin
          check("start_outside_frame", int'(in_frame), 0);
          if (stop_valid) check("bus_free_gap", int'(cyc - stop_cyc >= 4 * CLK_DIV), 1);
          in_frame = 1'b1; nbits = 0; nbytes = 0; acc = '0; shreg = '0;
          cur_frame = frame_no;
          frame_no++;
        end else begin
          check("stop_inside_frame", int'(in_frame), 1);
          in_frame = 1'b0;
          dec_q.push_back({8'(nbytes), acc});
          stop_cyc = cyc;
          stop_valid = 1'b1;
        end
      end
      if (!prev_scl && sclk && in_frame) begin
        rise_cyc = cyc;
        high_clean = 1'b1;
        if (nbits % 9 < 8) begin
          shreg = {shreg[6:0], line};
          if (nbits % 9 == 7) begin
            nk = (nbytes == 0 && shreg != 8'h34) ||
                 (nack_cnt > 0 && cur_frame >= nack_frame &&
                  cur_frame < nack_frame + nack_cnt && nbytes == nack_byte);
            ack_pull = !nk;
            ack_pending = 1'b1;
          end
        end else begin
          acc = {acc[15:0], shreg};
          nbytes++;
        end
        nbits++;
      end
      prev_scl = sclk; prev_sda = line; prev_busy = busy;
    end
  end

  function automatic logic [31:0] pack(input logic [15:0] wd, input int n);
    logic [23:0] b;
    if (n == 1)      b = {16'h0000, 8'h34};
    else if (n == 2) b = {8'h00, 8'h34, wd[15:8]};
    else             b = {8'h34, wd};
    return {8'(n), b};
  endfunction

  // Word-level reference: frames in order, total quarters, final flags.
  task automatic model(input int nf, input int nb, input int nc,
                       output int q, output bit e, output int w);
    int f = 0;
    int tries;
    int n;
    logic [15:0] wd;
    q = 0; e = 1'b0; w = 10;
    exp_q.delete();
    for (int k = 0; k < 11 && !e; k++) begin
      wd = {T_ADDR[k], T_DATA[k]};
      tries = 0;
      while (1) begin
        if (nc > 0 && f >= nf && f < nf + nc) begin
          n = nb + 1;
          exp_q.push_back(pack(wd, n));
          q += 2 + 36 * n + 7;
          f++; tries++;
          if (tries > MAX_RETRY) begin e = 1'b1; w = k; break; end
        end else begin
          exp_q.push_back(pack(wd, 3));
          q += 117;
          f++;
          break;
        end
      end
    end
  endtask

  task automatic run_check(input string tag, input int nf, input int nb, input int nc,
                           input bit pulse, input int mid);
    int q, w, mark, n;
    bit e, fin;
    nack_frame = nf; nack_byte = nb; nack_cnt = nc;
    model(nf, nb, nc, q, e, w);
    mark = busy_rises;
    if (pulse) begin
      @(negedge clk);
      start = 1'b1;
    end
    fin = 1'b0;
    for (int i = 0; i < q * CLK_DIV + 2000; i++) begin
      @(negedge clk);
      start = (i == mid);
      if (busy_rises != mark && (done || error)) begin fin = 1'b1; break; end
    end
    start = 1'b0;
    check({tag, "/finished"}, int'(fin), 1);
    check({tag, "/run_cycles"}, int'(cyc - busy_rise_cyc), q * CLK_DIV);
    check({tag, "/done"}, int'(done), int'(!e));
    check({tag, "/error"}, int'(error), int'(e));
    check({tag, "/busy"}, int'(busy), 0);
    check({tag, "/word_idx"}, int'(word_idx), w);
    check({tag, "/sclk_idle"}, int'(sclk), 1);
    check({tag, "/sdat_released"}, int'(sdat_oe), 0);
    check({tag, "/frame_count"}, dec_q.size(), exp_q.size());
    n = (dec_q.size() < exp_q.size()) ? dec_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s/frame%0d", tag, i), int'(dec_q[i]), int'(exp_q[i]));
  endtask

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    check("reset/sclk", int'(sclk), 1);
    check("reset/sdat_oe", int'(sdat_oe), 0);
    check("reset/busy", int'(busy), 0);
    check("reset/done", int'(done), 0);
    check("reset/error", int'(error), 0);
    check("reset/word_idx", int'(word_idx), 0);

    reset_n = 1'b1;
    run_check("clean", 0, 0, 0, 1'b0, -1);
    run_check("single_nack", 3, 1, 1, 1'b1, -1);
    run_check("persistent_nack", 5, 0, 4, 1'b1, -1);
    run_check("restart_midpulse", 0, 0, 0, 1'b1, int'($urandom_range(100, 4000)));
    run_check("random_a", int'($urandom_range(0, 13)), int'($urandom_range(0, 2)),
              int'($urandom_range(1, 4)), 1'b1, -1);
    run_check("random_b", int'($urandom_range(0, 13)), int'($urandom_range(0, 2)),
              int'($urandom_range(1, 4)), 1'b1, int'($urandom_range(50, 3000)));

    // asynchronous reset in the middle of word 4
    nack_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (busy && word_idx == 4'd4) begin found = 1'b1; break; end
    end
    check("async/reached_word4", int'(found), 1);
    repeat ($urandom_range(20, 400)) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async/sclk", int'(sclk), 1);
    check("async/sdat_oe", int'(sdat_oe), 0);
    check("async/busy", int'(busy), 0);
    check("async/done", int'(done), 0);
    check("async/error", int'(error), 0);
    check("async/word_idx", int'(word_idx), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run_check("after_reset", 0, 0, 0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/codec_config_sequencer.md
# codec_config_sequencer

Replaces the vendor audio/video configuration core. After reset it writes a fixed register table to the WM8731 audio codec over I2C and then reports the codec as ready. The table sets the codec as bus master (it drives BCLK and DACLRCK), I2S, 16-bit, 48 kHz, DAC to line-out. It sits between `clk`/`reset_n` and the `FPGA_I2C_SCLK`/`FPGA_I2C_SDAT` pins. `done` qualifies the audio path downstream.

## Interface
- `CLK_DIV`, 125: `clk` cycles per I2C quarter-bit. 125 at 50 MHz gives a 100 kHz SCL.
- `MAX_RETRY`, 3: retries allowed per word after a NACK, before the block declares an error.
- `DEV_ADDR`, 7'h1A: 7-bit codec address. The write address byte is 8'h34.
- `clk`  in  1: system clock (CLOCK_50).
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse that re-runs the whole table. Honoured only when `busy`=0.
- `sdat_in`  in  1: sampled level of the SDAT pin.
- `sclk`  out  1: SCL, push-pull.
- `sdat_oe`  out  1: 1 pulls SDAT low; 0 releases SDAT to the pull-up.
- `busy`  out  1: a table run is in progress.
- `done`  out  1: every word was ACKed. Stays high until the next run starts.
- `error`  out  1: a word exceeded `MAX_RETRY`. Stays high until the next run starts.
- `word_idx`  out  4: index of the word currently being written (0..10).

## Operation
- **Register table**, written in this order as {addr[6:0], data[8:0]}:
  - 0: R15=0x000 (reset)
  - 1: R6=0x000 (all blocks powered)
  - 2: R0=0x017
  - 3: R1=0x017
  - 4: R2=0x079
  - 5: R3=0x079
  - 6: R4=0x012
  - 7: R5=0x000
  - 8: R7=0x042 (master, I2S, 16-bit)
  - 9: R8=0x000
  - 10: R9=0x001 (active)
- **Frame for each word:** START, then 0x34, ACK, then {addr, data[8]}, ACK, then data[7:0], ACK, then STOP, then GAP. Bytes go MSB first.
- **Quarter-tick counter:** runs 0..CLK_DIV-1. The FSM advances one phase per tick.
- **FSM states:** IDLE, START, BIT, ACK, STOP, GAP, DONE, ERR.
  - IDLE → START: on the first cycle after reset is released (automatic run), or on `start` while in DONE or ERR.
  - START, 2 quarters: q0 has SCL=1, SDA low; q1 has SCL low.
  - BIT, 4 quarters per bit: q0 drives SDA with SCL=0; q1 holds SCL=0; q2 sets SCL=1; q3 keeps SCL=1.
  - ACK, 4 quarters: SDA is released. `sdat_in` is sampled on the last cycle of q2. A sample of 0 is ACK; a sample of 1 is NACK.
  - STOP, 3 quarters: SDA low with SCL=0; then SCL=1; then SDA released.
  - GAP, 4 quarters: both lines high.
  - After GAP, on an ACKed word: `word_idx`+1. After word 10 the FSM goes to DONE.
- **NACK:** abort the remaining bytes, go to STOP then GAP, and retry the same word. The retry counter resets on every new word. A NACK on retry number MAX_RETRY goes to ERR.
- **Clock stretching** is not supported. SCL is driven, not open-drain.
- **Status flags:**
  - DONE: `done`=1, `busy`=0.
  - ERR: `error`=1, `busy`=0, `word_idx` frozen at the failing word.
  - Every run start clears `done`, `error`, `word_idx` and the retry count.
- **`start` is ignored while `busy`=1**, including a pulse on the same cycle as a NACK.

## Timing
- **Reset values:** `sclk`=1, `sdat_oe`=0, `busy`=0, `done`=0, `error`=0, `word_idx`=0, FSM=IDLE, counters 0.
- **Run start:** `busy` rises on the first `clk` edge after `reset_n` deasserts. The START q0 phase begins on that same cycle.
- **Word length:** an ACKed word takes 2+108+3+4 = 117 quarters = 117·CLK_DIV cycles.
- **NACK cost:** a word NACKed at ACK k (k=1..3) takes 2 + 36·k + 7 quarters.
- **Full clean run:** 11·117·CLK_DIV cycles from `busy` rising to `done` rising. `busy` falls on the same edge that `done` rises.
- **Outputs are registered.** SCL and SDA edges align to quarter boundaries, and SDA changes only while SCL=0, except in START and STOP.
- **`reset_n` asserted mid-frame:** all outputs return to their reset values immediately (asynchronously). The bus is released; a truncated byte is acceptable. The codec recovers through the next START.

## Test plan
- **Clean run:** CLK_DIV=4, bench slave ACKs everything. Expect `done` 5148 cycles after `busy` rises, `error`=0, and 11 decoded writes matching the table exactly, including R7=0x042 and last word R9=0x001.
- **Single NACK:** slave NACKs the first attempt at word 3, second byte. Expect STOP, a retry of R1=0x017, then `done`=1. Total is 5148 + (2+72+7)·4 = 5472 cycles.
- **Persistent NACK:** slave always NACKs the address byte at word 5 (MAX_RETRY=3). Expect 4 attempts, `error`=1, `word_idx`=5, `busy`=0, SDAT released and SCL=1.
- **Restart:** `start` pulse while in ERR or DONE clears the flags, restarts at word 0, and the run completes. A `start` pulse mid-run has no effect; the frame count stays at 11.
- **Async reset:** assert `reset_n`=0 mid-bit of word 4. Expect outputs at reset values before the next edge. After release, a complete run starts from word 0.
- **Bus protocol checker over every run:** no SDA transitions while SCL=1 except START/STOP, a bus-free gap of at least 4 quarters between frames, and SCL high time equal to 2·CLK_DIV cycles.
